// File: rtl/riscv_multicycle_controller.sv
// Microstep control FSM for the multicycle RISC-V datapath.
// One state per clock; every datapath control is decoded combinationally from state and instruction fields.
module riscv_multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       zero,
    output logic       PCWriteEn,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ImmSrc,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LUI      = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    state_t state_q;
    state_t state_d;

    // The sub flag lets EXECI reuse the R-type decode with func7 masked off.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  alu_decode = sub ? ALU_SUB : ALU_ADD;
            3'b111:  alu_decode = ALU_AND;
            3'b110:  alu_decode = ALU_OR;
            3'b010:  alu_decode = ALU_SLT;
            3'b011:  alu_decode = ALU_SLTU;
            3'b100:  alu_decode = ALU_XOR;
            default: alu_decode = ALU_ADD;
        endcase
    endfunction

    // blt/bge compute SLT, so a zero result means rs1 >= rs2.
    function automatic logic branch_taken(input logic [2:0] f3, input logic z);
        case (f3)
            3'b000:  branch_taken = z;
            3'b001:  branch_taken = !z;
            3'b100:  branch_taken = !z;
            3'b101:  branch_taken = z;
            default: branch_taken = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECR;
                    OP_ITYPE:  state_d = S_EXECI;
                    OP_BRANCH: state_d = S_BRANCH;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI:    state_d = S_LUI;
                    default:   state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_JALR:     state_d = S_JAL;
            S_LUI:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWriteEn  = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_B;
        ALUControl = ALU_ADD;
        ImmSrc     = IMM_I;
        // Everything reads zero while reset is held, whatever state_q holds.
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    PCWriteEn = 1'b1;
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = (op == OP_JAL) ? IMM_J : IMM_B;
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_A;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    AdrSrc    = 1'b1;
                    ResultSrc = RES_ALUOUT;
                end
                S_MEMWB: begin
                    ResultSrc = RES_MDR;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc    = 1'b1;
                    ResultSrc = RES_ALUOUT;
                    MemWrite  = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA    = SRCA_A;
                    ALUSrcB    = SRCB_B;
                    ALUControl = alu_decode(func3, func7);
                end
                S_EXECI: begin
                    ALUSrcA    = SRCA_A;
                    ALUSrcB    = SRCB_IMM;
                    ImmSrc     = IMM_I;
                    ALUControl = alu_decode(func3, 1'b0);
                end
                S_ALUWB: begin
                    ResultSrc = RES_ALUOUT;
                    RegWrite  = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA   = SRCA_A;
                    ALUSrcB   = SRCB_B;
                    ResultSrc = RES_ALUOUT;
                    case (func3)
                        3'b000, 3'b001: ALUControl = ALU_SUB;
                        3'b100, 3'b101: ALUControl = ALU_SLT;
                        default:        ALUControl = ALU_ADD;
                    endcase
                    PCWriteEn = branch_taken(func3, zero);
                end
                S_JAL: begin
                    ResultSrc = RES_ALUOUT;
                    PCWriteEn = 1'b1;
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_FOUR;
                end
                S_JALR: begin
                    ALUSrcA = SRCA_A;
                    ALUSrcB = SRCB_IMM;
                    ImmSrc  = IMM_I;
                end
                S_LUI: begin
                    ImmSrc    = IMM_U;
                    ResultSrc = RES_IMM;
                    RegWrite  = 1'b1;
                end
                default: begin
                    PCWriteEn = 1'b0;
                end
            endcase
        end
    end

    assign state = state_q;

endmodule
